// File: rtl/message_decoder.sv
// message_decoder
//   BFV plaintext decode stage. For each ciphertext-domain coefficient x it
//   computes m = round(t*x/q) mod t. The division by q is done by a restoring
//   divider, one quotient bit per cycle. Decoded coefficients are emitted
//   with a valid/ready handshake, and out_last flags index N-1 of each
//   polynomial.
//
// Ports
//   clk        single clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   coeff_in valid
//   coeff_in   coefficient x, 0 <= x < q
//   in_ready   decoder idle and able to accept coeff_in
//   out_valid  msg_out / out_last valid
//   msg_out    decoded plaintext coefficient, 0 <= m < t
//   out_last   msg_out is coefficient N-1 of the current polynomial
//   out_ready  downstream consumes msg_out
module message_decoder #(
    parameter int q    = 17,
    parameter int N    = 8,
    parameter int logq = 5,
    parameter int logN = 3,
    parameter int t    = 4,
    parameter int logt = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [logq-1:0] coeff_in,
    output logic            in_ready,
    output logic            out_valid,
    output logic [logt-1:0] msg_out,
    output logic            out_last,
    input  logic            out_ready
);

    localparam int QW = logt + 1;         // quotient width, Q <= t
    localparam int DW = logq + logt + 1;  // dividend width
    localparam int RW = logq + 1;         // partial remainder width
    localparam int CW = $clog2(QW);

    localparam logic [DW-1:0]   T_D      = DW'(t);
    localparam logic [DW-1:0]   HALF_D   = DW'(q >> 1);
    localparam logic [RW-1:0]   Q_R      = RW'(q);
    localparam logic [QW-1:0]   T_Q      = QW'(t);
    localparam logic [CW-1:0]   CNT_INIT = CW'(QW - 1);
    localparam logic [logN-1:0] LAST_IDX = logN'(N - 1);

    typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

    state_t          state;
    logic [QW-1:0]   low;    // dividend bits still to be shifted in, MSB first
    logic [RW-1:0]   rem;
    logic [QW-1:0]   quot;
    logic [CW-1:0]   cnt;
    logic [logN-1:0] idx;

    // Rounding is folded into the dividend: round(t*x/q) = floor((t*x + q/2)/q).
    logic [DW-1:0] dividend;
    always_comb dividend = T_D * DW'(coeff_in) + HALF_D;

    // One restoring-division step.
    logic [RW-1:0] rem_sh;
    logic [RW-1:0] rem_nx;
    logic          q_bit;
    logic [QW-1:0] quot_nx;

    always_comb begin
        rem_sh  = {rem[logq-1:0], low[QW-1]};
        q_bit   = (rem_sh >= Q_R);
        rem_nx  = q_bit ? (rem_sh - Q_R) : rem_sh;
        quot_nx = {quot[QW-2:0], q_bit};
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign out_last  = out_valid && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            low     <= '0;
            rem     <= '0;
            quot    <= '0;
            cnt     <= '0;
            msg_out <= '0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // D < (t+1)*q <= 2^QW * q, so the top logq bits
                        // preloaded here are already below q and exactly QW
                        // iterations yield floor(D/q).
                        rem   <= {1'b0, dividend[DW-1:QW]};
                        low   <= dividend[QW-1:0];
                        quot  <= '0;
                        cnt   <= CNT_INIT;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem  <= rem_nx;
                    low  <= {low[QW-2:0], 1'b0};
                    quot <= quot_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        // Q == t means round(t*x/q) == t, i.e. 0 mod t.
                        msg_out <= (quot_nx == T_Q) ? '0 : quot_nx[logt-1:0];
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        idx   <= idx + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_message_decoder.sv
module tb_message_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [4:0] coeff_in;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] msg_out;
    logic       out_last;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    message_decoder #(.q(17), .N(8), .logq(5), .logN(3), .t(4), .logt(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .coeff_in (coeff_in),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .msg_out  (msg_out),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference: round(4x/17) mod 4.
    function automatic logic [1:0] model(input int x);
        return 2'(((4 * x + 8) / 17) % 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #3;
        reset_n  = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        coeff_in  = '0;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (msg_out !== 2'd0) begin n_fail++; $display("FAIL reset_msg_out got=%0d exp=0", msg_out); end
        n_checks++;
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_vectors();
        int xs [7];
        int ex [7];
        int cyc;
        xs = '{0, 2, 3, 4, 9, 13, 16};
        ex = '{0, 0, 1, 1, 2, 3, 0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            coeff_in = 5'(xs[i]);
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec_in_ready x=%0d got=%b exp=1", xs[i], in_ready); end
            tick();
            in_valid = 1'b0;
            cyc = 1;
            while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
            n_checks++;
            if (cyc !== 4) begin n_fail++; $display("FAIL vec_latency x=%0d got=%0d exp=4", xs[i], cyc); end
            n_checks++;
            if (msg_out !== 2'(ex[i])) begin n_fail++; $display("FAIL vec_msg x=%0d got=%0d exp=%0d", xs[i], msg_out, ex[i]); end
            tick();
        end
    endtask

    task automatic test_stream();
        int cyc;
        logic exp_last;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1;
            coeff_in = 5'(k % 17);
            tick();
            in_valid = 1'b0;
            cyc = 1;
            while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
            exp_last = (k == 7) || (k == 15);
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_timeout k=%0d got=%b exp=1", k, out_valid); end
            n_checks++;
            if (out_last !== exp_last) begin n_fail++; $display("FAIL stream_last k=%0d got=%b exp=%b", k, out_last, exp_last); end
            n_checks++;
            if (msg_out !== model(k % 17)) begin n_fail++; $display("FAIL stream_msg k=%0d got=%0d exp=%0d", k, msg_out, model(k % 17)); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        coeff_in  = 5'd9;
        tick();
        coeff_in = 5'd3;  // held valid while busy, must be ignored
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || msg_out !== 2'd2 || in_ready !== 1'b0 || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got v=%b m=%0d r=%b l=%b exp v=1 m=2 r=0 l=0",
                         i, out_valid, msg_out, in_ready, out_last);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();  // output handshake
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
        end
        tick();  // held input x=3 accepted here
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept got in_ready=%b exp=0", in_ready); end
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        n_checks++;
        if (msg_out !== 2'd1 || cyc !== 4) begin
            n_fail++; $display("FAIL bp_next got msg=%0d lat=%0d exp msg=1 lat=4", msg_out, cyc);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        int cyc;
        int seen;
        do_reset();
        out_ready = 1'b1;
        // Move the index to 7 so a surviving index would flag out_last.
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            coeff_in = 5'd0;
            tick();
            in_valid = 1'b0;
            cyc = 1;
            while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
            tick();
        end
        in_valid = 1'b1;
        coeff_in = 5'd13;
        tick();  // accepted, first DIV cycle
        in_valid = 1'b0;
        tick();  // second DIV cycle
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || msg_out !== 2'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_vals got r=%b v=%b m=%0d l=%b exp r=1 v=0 m=0 l=0",
                     in_ready, out_valid, msg_out, out_last);
        end
        #1;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_no_output got=%0d exp=0", seen); end
        in_valid = 1'b1;
        coeff_in = 5'd4;
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        n_checks++;
        if (msg_out !== 2'd1 || out_last !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_after got v=%b m=%0d l=%b exp v=1 m=1 l=0", out_valid, msg_out, out_last);
        end
        tick();
    endtask

    task automatic test_exhaustive();
        int got;
        int extra;
        do_reset();
        got = 0;
        fork
            begin
                int gap;
                int w;
                logic acc;
                for (int x = 0; x < 17; x++) begin
                    in_valid = 1'b0;
                    gap = $urandom_range(0, 3);
                    repeat (gap) tick();
                    in_valid = 1'b1;
                    coeff_in = 5'(x);
                    w = 0;
                    acc = 1'b0;
                    while (!acc && w < 100) begin
                        acc = in_ready;
                        tick();
                        w++;
                    end
                    in_valid = 1'b0;
                    if (!acc) break;
                end
            end
            begin
                int w;
                logic exp_last;
                w = 0;
                while (got < 17 && w < 3000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        exp_last = (got % 8) == 7;
                        n_checks++;
                        if (msg_out !== model(got) || out_last !== exp_last) begin
                            n_fail++;
                            $display("FAIL exh_out n=%0d got m=%0d l=%b exp m=%0d l=%b",
                                     got, msg_out, out_last, model(got), exp_last);
                        end
                        got++;
                    end
                    tick();
                    w++;
                end
                out_ready = 1'b1;
            end
        join
        n_checks++;
        if (got !== 17) begin n_fail++; $display("FAIL exh_count got=%0d exp=17", got); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) extra++;
            tick();
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL exh_extra got=%0d exp=0", extra); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stream();
        test_backpressure();
        test_reset_mid_div();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
